// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width helpers for the
// write-back cache controller FSM.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMP_RD,
    COMP_WR,
    WB,
    WB_WAIT,
    ALLOC,
    FILL_DRAIN
  } state_e;

  localparam int unsigned DEF_WORDS   = 4;
  localparam int unsigned DEF_MEM_LAT = 2;

  function automatic int unsigned beat_w(
    input int unsigned words
  );
    return $clog2(words);
  endfunction

  function automatic int unsigned off_w(
    input int unsigned words
  );
    return beat_w(words) + 1;
  endfunction

  function automatic int unsigned lat_w(
    input int unsigned lat
  );
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// Controller bundle: cache array, banked memory and status.
// master = controller, slave = surrounding mem_system.
interface cache_ctrl_fsm_if #(
  parameter int unsigned OFF_W = 3
);
  logic             rd_en;
  logic             wr_en;
  logic [OFF_W-1:0] req_offset;
  logic             hit;
  logic             dirty;
  logic             valid;
  logic             mem_busy;
  logic             comp;
  logic             write;
  logic             valid_in;
  logic             sel_data_cache;
  logic [OFF_W-1:0] cache_offset;
  logic             rd_mem;
  logic             wr_mem;
  logic             sel_tag_mem;
  logic [OFF_W-1:0] mem_offset;
  logic             done;
  logic             cache_hit;
  logic             stall;
  logic             err;

  modport master (
    input  rd_en, wr_en, req_offset,
    input  hit, dirty, valid, mem_busy,
    output comp, write, valid_in,
    output sel_data_cache, cache_offset,
    output rd_mem, wr_mem, sel_tag_mem,
    output mem_offset,
    output done, cache_hit, stall, err
  );

  modport slave (
    output rd_en, wr_en, req_offset,
    output hit, dirty, valid, mem_busy,
    input  comp, write, valid_in,
    input  sel_data_cache, cache_offset,
    input  rd_mem, wr_mem, sel_tag_mem,
    input  mem_offset,
    input  done, cache_hit, stall, err
  );
endinterface

// File: rtl/fill_pipe.sv
// Tracks accepted memory read beats until their data
// returns LAT cycles later and is written into the cache.
module fill_pipe #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned OFF_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic             out_valid_o,
  output logic [OFF_W-1:0] out_offset_o,
  output logic             empty_o
);
  localparam logic [LAT-1:0] OUT_BIT =
    LAT'(1) << (LAT - 1);

  logic [LAT-1:0]   v_q;
  logic [OFF_W-1:0] off_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) off_q[k] <= '0;
    end else begin
      v_q[0]   <= push_i;
      off_q[0] <= offset_i;
      for (int k = 1; k < LAT; k++) begin
        v_q[k]   <= v_q[k-1];
        off_q[k] <= off_q[k-1];
      end
    end
  end

  assign out_valid_o  = v_q[LAT-1];
  assign out_offset_o = off_q[LAT-1];
  // Drained once nothing remains behind the output stage.
  assign empty_o = !push_i && ((v_q & ~OUT_BIT) == '0);
endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-back cache controller with
// configurable line size, memory latency and back-pressure.
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WORDS   = DEF_WORDS,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT,
  parameter int unsigned OFF_W   = off_w(WORDS)
) (
  input logic              clk,
  input logic              rst,
  cache_ctrl_fsm_if.master bus
);
  localparam int unsigned BW = beat_w(WORDS);
  localparam int unsigned CW = lat_w(MEM_LAT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);
  localparam logic [OFF_W-1:0] LAST_OFF =
    OFF_W'(2 * (WORDS - 1));

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             is_wr_q, is_wr_d;
  logic             missed_q, missed_d;
  logic             push, fill_v, fill_empty;
  logic [OFF_W-1:0] fill_off, beat_off;

  assign beat_off = OFF_W'({beat_q, 1'b0});
  assign push = (state_q == ALLOC) && !bus.mem_busy;

  fill_pipe #(
    .LAT  (MEM_LAT),
    .OFF_W(OFF_W)
  ) u_fill (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .offset_i    (beat_off),
    .out_valid_o (fill_v),
    .out_offset_o(fill_off),
    .empty_o     (fill_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      off_q    <= '0;
      is_wr_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      off_q    <= off_d;
      is_wr_q  <= is_wr_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    off_d    = off_q;
    is_wr_d  = is_wr_q;
    missed_d = missed_q;
    unique case (state_q)
      IDLE: begin
        off_d    = bus.req_offset;
        is_wr_d  = bus.wr_en;
        missed_d = 1'b0;
        if (bus.rd_en && !bus.wr_en) state_d = COMP_RD;
        else if (bus.wr_en && !bus.rd_en) state_d = COMP_WR;
      end
      COMP_RD, COMP_WR: begin
        if (bus.valid && bus.hit) begin
          state_d = IDLE;
        end else begin
          beat_d   = '0;
          missed_d = 1'b1;
          state_d  = (bus.valid && bus.dirty) ? WB : ALLOC;
        end
      end
      WB: begin
        if (!bus.mem_busy) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = WB_WAIT;
            wait_d  = CW'(MEM_LAT - 1);
          end
        end
      end
      WB_WAIT: begin
        if (wait_q == '0) begin
          state_d = ALLOC;
          beat_d  = '0;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ALLOC: begin
        if (!bus.mem_busy) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = FILL_DRAIN;
        end
      end
      FILL_DRAIN: begin
        if (fill_empty) state_d = is_wr_q ? COMP_WR : COMP_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.comp           = 1'b0;
    bus.write          = 1'b0;
    bus.valid_in       = 1'b0;
    bus.sel_data_cache = 1'b0;
    bus.cache_offset   = '0;
    bus.rd_mem         = 1'b0;
    bus.wr_mem         = 1'b0;
    bus.sel_tag_mem    = 1'b0;
    bus.mem_offset     = '0;
    bus.done           = 1'b0;
    bus.cache_hit      = 1'b0;
    bus.err            = 1'b0;
    bus.stall          = (state_q != IDLE);
    unique case (state_q)
      IDLE: bus.err = bus.rd_en && bus.wr_en;
      COMP_RD, COMP_WR: begin
        bus.comp         = 1'b1;
        bus.write        = (state_q == COMP_WR);
        bus.cache_offset = off_q;
        if (bus.valid && bus.hit) begin
          bus.done      = 1'b1;
          bus.cache_hit = !missed_q;
        end
      end
      WB: begin
        bus.wr_mem       = 1'b1;
        bus.sel_tag_mem  = 1'b1;
        bus.mem_offset   = beat_off;
        bus.cache_offset = beat_off;
      end
      ALLOC: begin
        bus.rd_mem     = 1'b1;
        bus.mem_offset = beat_off;
      end
      WB_WAIT, FILL_DRAIN: begin
      end
      default: bus.err = 1'b1;
    endcase
    // Returning fill data owns the cache write port.
    if (fill_v) begin
      bus.write          = 1'b1;
      bus.sel_data_cache = 1'b1;
      bus.cache_offset   = fill_off;
      bus.valid_in       = (fill_off == LAST_OFF);
    end
  end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: two configurations, directed and
// random transactions checked against an event-time model.
module tb_cache_ctrl_fsm;
  localparam int MAXC = 256;

  typedef struct packed {
    logic       comp;
    logic       write;
    logic       valid_in;
    logic       sel_dc;
    logic [4:0] coff;
    logic       rd_mem;
    logic       wr_mem;
    logic       sel_tag;
    logic [4:0] moff;
    logic       done;
    logic       chit;
    logic       stall;
    logic       err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  obs_t exp_q  [MAXC];
  bit   busy_q [MAXC];
  bit   dv_q   [MAXC];
  bit   dh_q   [MAXC];
  bit   dd_q   [MAXC];

  cache_ctrl_fsm_if #(.OFF_W(3)) bus_a ();
  cache_ctrl_fsm_if #(.OFF_W(4)) bus_b ();

  cache_ctrl_fsm #(.WORDS(4), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  cache_ctrl_fsm #(.WORDS(8), .MEM_LAT(5)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.comp, bus_a.write,
    bus_a.valid_in, bus_a.sel_data_cache,
    5'(bus_a.cache_offset), bus_a.rd_mem,
    bus_a.wr_mem, bus_a.sel_tag_mem,
    5'(bus_a.mem_offset), bus_a.done,
    bus_a.cache_hit, bus_a.stall, bus_a.err};
  assign obs_b = {bus_b.comp, bus_b.write,
    bus_b.valid_in, bus_b.sel_data_cache,
    5'(bus_b.cache_offset), bus_b.rd_mem,
    bus_b.wr_mem, bus_b.sel_tag_mem,
    5'(bus_b.mem_offset), bus_b.done,
    bus_b.cache_hit, bus_b.stall, bus_b.err};

  task automatic drive(input int inst, input bit rd,
      input bit wr, input logic [4:0] off, input bit v,
      input bit h, input bit d, input bit bz);
    if (inst == 0) begin
      bus_a.rd_en      = rd;
      bus_a.wr_en      = wr;
      bus_a.req_offset = off[2:0];
      bus_a.valid      = v;
      bus_a.hit        = h;
      bus_a.dirty      = d;
      bus_a.mem_busy   = bz;
    end else begin
      bus_b.rd_en      = rd;
      bus_b.wr_en      = wr;
      bus_b.req_offset = off[3:0];
      bus_b.valid      = v;
      bus_b.hit        = h;
      bus_b.dirty      = d;
      bus_b.mem_busy   = bz;
    end
  endtask

  task automatic check(input int inst, input string tag,
      input int c);
    obs_t o;
    o = (inst == 0) ? obs_a : obs_b;
    checks++;
    assert (o === exp_q[c]) else begin
      errors++;
      $error("FAIL %s cyc %0d: observed %b expected %b",
        tag, c, o, exp_q[c]);
    end
  endtask

  task automatic cmp_at(input int c, input bit is_wr,
      input logic [4:0] off);
    exp_q[c].comp  = 1'b1;
    exp_q[c].write = is_wr;
    exp_q[c].coff  = off;
  endtask

  // kind: 0 hit, 1 clean miss, 2 dirty miss, 3 rd+wr error.
  // Computes when each beat is accepted and when its fill
  // data returns, then paints the expected waveform.
  task automatic plan(input int inst, input int kind,
      input bit is_wr, input logic [4:0] off,
      input int bmode, input int rst_at, output int last);
    int w, l, c;
    bit acc;
    w = (inst == 0) ? 4 : 8;
    l = (inst == 0) ? 2 : 5;
    for (int i = 0; i < MAXC; i++) begin
      exp_q[i] = '0;
      exp_q[i].stall = 1'b1;
      dv_q[i] = 1'($urandom);
      dh_q[i] = 1'($urandom);
      dd_q[i] = 1'($urandom);
      case (bmode)
        0: busy_q[i] = (i < 150) &&
                       ($urandom_range(0, 9) < 3);
        2: busy_q[i] = (i >= 3) && (i <= 5);
        default: busy_q[i] = 1'b0;
      endcase
    end
    exp_q[0].stall = 1'b0;
    if (kind == 3) begin
      exp_q[0].err = 1'b1;
      last = 0;
    end else begin
      cmp_at(1, is_wr, off);
      if (kind == 0) begin
        dv_q[1] = 1'b1;
        dh_q[1] = 1'b1;
        exp_q[1].done = 1'b1;
        exp_q[1].chit = 1'b1;
        last = 1;
      end else begin
        if (kind == 2) begin
          dv_q[1] = 1'b1;
          dh_q[1] = 1'b0;
          dd_q[1] = 1'b1;
        end else if (dv_q[1]) begin
          dh_q[1] = 1'b0;
          dd_q[1] = 1'b0;
        end
        c = 2;
        if (kind == 2) begin
          for (int bt = 0; bt < w; bt++) begin
            acc = 1'b0;
            while (!acc) begin
              exp_q[c].wr_mem  = 1'b1;
              exp_q[c].sel_tag = 1'b1;
              exp_q[c].moff    = 5'(2 * bt);
              exp_q[c].coff    = 5'(2 * bt);
              acc = !busy_q[c];
              c++;
            end
          end
          c += l;
        end
        for (int bt = 0; bt < w; bt++) begin
          acc = 1'b0;
          while (!acc) begin
            exp_q[c].rd_mem = 1'b1;
            exp_q[c].moff   = 5'(2 * bt);
            if (!busy_q[c]) begin
              acc = 1'b1;
              exp_q[c+l].write    = 1'b1;
              exp_q[c+l].sel_dc   = 1'b1;
              exp_q[c+l].coff     = 5'(2 * bt);
              exp_q[c+l].valid_in = (bt == w - 1);
            end
            c++;
          end
        end
        c += l;
        cmp_at(c, is_wr, off);
        dv_q[c] = 1'b1;
        dh_q[c] = 1'b1;
        exp_q[c].done = 1'b1;
        last = c;
      end
    end
    if (rst_at > 0) begin
      for (int i = rst_at + 1; i < MAXC; i++)
        exp_q[i] = '0;
      last = rst_at + l + 1;
    end
    exp_q[last+1] = '0;
  endtask

  task automatic run(input int inst, input string tag,
      input int kind, input bit is_wr, input int off_in,
      input int bmode, input int rst_at);
    int last, w;
    logic [4:0] off;
    bit rd, wr;
    w = (inst == 0) ? 4 : 8;
    if (off_in < 0) off = 5'(2 * $urandom_range(0, w - 1));
    else off = 5'(off_in);
    plan(inst, kind, is_wr, off, bmode, rst_at, last);
    for (int c = 0; c <= last + 1; c++) begin
      rst = (rst_at > 0) && (c == rst_at);
      rd = (c == 0) && ((kind == 3) || !is_wr);
      wr = (c == 0) && ((kind == 3) || is_wr);
      drive(inst, rd, wr, (c == 0) ? off : 5'($urandom),
        dv_q[c], dh_q[c], dd_q[c], busy_q[c]);
      @(negedge clk);
      check(inst, tag, c);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive(inst, 0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q[0] = '0;
    @(negedge clk);
    check(0, "reset_a", 0);
    check(1, "reset_b", 0);
    @(posedge clk);
    #1;

    run(0, "rd_hit",        0, 1'b0,  6, 1, 0);
    run(0, "wr_hit",        0, 1'b1, -1, 1, 0);
    run(0, "rd_clean",      1, 1'b0, -1, 1, 0);
    run(0, "wr_dirty",      2, 1'b1, -1, 1, 0);
    run(0, "busy_alloc",    1, 1'b0, -1, 2, 0);
    run(0, "both_err",      3, 1'b0, -1, 1, 0);
    run(0, "hit_after_err", 0, 1'b0, -1, 1, 0);
    run(0, "rst_alloc",     1, 1'b0, -1, 1, 3);
    run(0, "after_rst",     1, 1'b1, -1, 1, 0);
    run(1, "both_err_w8",   3, 1'b0, -1, 1, 0);
    run(1, "rd_clean_w8",   1, 1'b0, -1, 1, 0);
    run(1, "wr_dirty_w8",   2, 1'b1, -1, 1, 0);
    run(1, "busy_w8",       2, 1'b0, -1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int inst, kind;
      inst = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      run(inst, "rand", kind, 1'($urandom), -1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
